// File: rtl/apb_intercon_s_pkg.sv
// Shared FSM encoding, default widths and index-width helper for the APB interconnect.
// Pure declarations; no timing or flow-control behaviour lives here.
package apb_intercon_s_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int DEF_BUS_WIDTH  = 16;
  localparam int DEF_DATA_WIDTH = 16;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_intercon_s_arbiter.sv
// Round-robin pick among requesters, searching upward from last_grant+1 with wrap.
// Combinational, zero latency; no backpressure, the caller decides when to sample.
module apb_rr_arbiter
  import apb_intercon_s_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          grant_vld
);

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int cand;
      cand = (int'(last_grant) + k) % N;
      if (!grant_vld && req[cand]) begin
        grant     = IW'(cand);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_intercon_s.sv
// N-master to shared-slave-bus APB interconnect: one arbitrated transfer at a time, IDLE->SETUP->ACCESS.
// Minimum 3 cycles per transfer; slave wait states stall ACCESS indefinitely, masters see S_PREADY only on completion.
module apb_intercon_s
  import apb_intercon_s_pkg::*;
#(
  parameter int MASTER_PORTS = 4,
  parameter int SLAVE_PORTS  = 4,
  parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_MSB     = 7,
  parameter int ADDR_LSB     = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSELx,
  input  logic [MASTER_PORTS-1:0]            S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [BUS_WIDTH-1:0]               M_PADDR,
  output logic                               M_PWRITE,
  output logic [SLAVE_PORTS-1:0]             M_PSELx,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]             M_PREADY
);

  localparam int GW = idx_width(MASTER_PORTS);
  localparam int SW = ADDR_MSB - ADDR_LSB + 1;

  logic [1:0]            state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         arb_grant;
  logic                  arb_vld;
  logic [BUS_WIDTH-1:0]  paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [SW-1:0]         slv_idx;
  logic                  slv_valid;
  logic                  slv_ready;
  logic [DATA_WIDTH-1:0] slv_rdata;
  logic                  active;
  logic                  done;

  // S_PENABLE carries no information the request decision needs.
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  apb_rr_arbiter #(.N(MASTER_PORTS), .IW(GW)) u_arb (
    .req        (S_PSELx),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_vld  (arb_vld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GW'(MASTER_PORTS - 1);
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            grant    <= arb_grant;
            paddr_q  <= S_PADDR[arb_grant*BUS_WIDTH +: BUS_WIDTH];
            pwrite_q <= S_PWRITE[arb_grant];
            pwdata_q <= S_PWDATA[arb_grant*DATA_WIDTH +: DATA_WIDTH];
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: state <= ST_ACCESS;
        ST_ACCESS: begin
          if (done) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign slv_idx   = paddr_q[ADDR_MSB:ADDR_LSB];
  assign slv_valid = (int'(slv_idx) < SLAVE_PORTS);

  // Loop-based select keeps out-of-range indices from reading past the buses.
  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = '0;
    for (int s = 0; s < SLAVE_PORTS; s++) begin
      if (int'(slv_idx) == s) begin
        slv_ready = M_PREADY[s];
        slv_rdata = M_PRDATA[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign active = (state == ST_SETUP) || (state == ST_ACCESS);
  // An undecoded address completes at once so the master is never stuck.
  assign done   = (state == ST_ACCESS) && (slv_valid ? slv_ready : 1'b1);

  always_comb begin
    M_PADDR   = active ? paddr_q  : '0;
    M_PWRITE  = active ? pwrite_q : 1'b0;
    M_PWDATA  = active ? pwdata_q : '0;
    M_PENABLE = (state == ST_ACCESS);
    M_PSELx   = '0;
    for (int s = 0; s < SLAVE_PORTS; s++) begin
      M_PSELx[s] = active && (int'(slv_idx) == s);
    end
    S_PREADY = '0;
    S_PRDATA = '0;
    for (int m = 0; m < MASTER_PORTS; m++) begin
      if (done && (int'(grant) == m)) begin
        S_PREADY[m] = 1'b1;
        S_PRDATA[m*DATA_WIDTH +: DATA_WIDTH] = (slv_valid && !pwrite_q) ? slv_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_intercon_s.sv
// Directed bench for apb_intercon_s: vector table of single transfers plus hand-written
// sequences for held requests, contention, wait states and reset during ACCESS.
module tb_apb_intercon_s;
  localparam int MP = 4;
  localparam int SP = 4;
  localparam int BW = 16;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [MP*BW-1:0] S_PADDR;
  logic [MP-1:0]    S_PWRITE;
  logic [MP-1:0]    S_PSELx;
  logic [MP-1:0]    S_PENABLE;
  logic [MP*DW-1:0] S_PWDATA;
  logic [MP*DW-1:0] S_PRDATA;
  logic [MP-1:0]    S_PREADY;
  logic [BW-1:0]    M_PADDR;
  logic             M_PWRITE;
  logic [SP-1:0]    M_PSELx;
  logic             M_PENABLE;
  logic [DW-1:0]    M_PWDATA;
  logic [SP*DW-1:0] M_PRDATA;
  logic [SP-1:0]    M_PREADY;

  always #5 clk = ~clk;

  apb_intercon_s dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic [15:0] a, input logic w, input logic [15:0] d);
    S_PADDR[m*BW +: BW]  = a;
    S_PWRITE[m]          = w;
    S_PWDATA[m*DW +: DW] = d;
    S_PSELx[m]           = 1'b1;
    S_PENABLE[m]         = 1'b1;
  endtask

  typedef struct {
    int          m;
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [3:0]  exp_sel;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        vecs[7];
  int          exp_hold[6];
  int          exp_order[3];
  int          order[$];
  int          pulses[4];
  logic [63:0] e_prd;
  logic [3:0]  e_rdy;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2, 16'h0025, 1'b0, 16'h0000, 4'b0100, 16'hBEEF};
    vecs[1] = '{0, 16'h0010, 1'b1, 16'h1234, 4'b0010, 16'h0000};
    vecs[2] = '{1, 16'h0030, 1'b0, 16'h5A5A, 4'b1000, 16'h4444};
    vecs[3] = '{3, 16'h0000, 1'b0, 16'h0001, 4'b0001, 16'h1111};
    vecs[4] = '{0, 16'h0050, 1'b0, 16'h0000, 4'b0000, 16'h0000};
    vecs[5] = '{3, 16'h0F17, 1'b0, 16'hCAFE, 4'b0010, 16'h2222};
    vecs[6] = '{1, 16'h00F0, 1'b1, 16'h7777, 4'b0000, 16'h0000};
    exp_hold  = '{0, 1, 0, 0, 1, 0};
    exp_order = '{0, 1, 3};

    M_PRDATA  = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    M_PREADY  = 4'hF;
    S_PADDR   = '0;
    S_PWRITE  = '0;
    S_PSELx   = '0;
    S_PENABLE = '0;
    S_PWDATA  = '0;
    reset     = 1'b1;

    // Request during reset must not leak through.
    set_master(1, 16'h0010, 1'b1, 16'hFFFF);
    repeat (5) tick();
    chk("rst psel",   M_PSELx, 0);
    chk("rst penable", M_PENABLE, 0);
    chk("rst paddr",  M_PADDR, 0);
    chk("rst pwrite", M_PWRITE, 0);
    chk("rst pwdata", M_PWDATA, 0);
    chk("rst sready", S_PREADY, 0);
    chk("rst sprdata", S_PRDATA, 0);
    S_PSELx = '0;
    reset   = 1'b0;
    tick();
    chk("idle psel", M_PSELx, 0);

    for (int i = 0; i < 7; i++) begin
      set_master(vecs[i].m, vecs[i].addr, vecs[i].wr, vecs[i].wdata);
      tick();
      S_PSELx = '0;
      chk($sformatf("v%0d setup psel", i),    M_PSELx,   vecs[i].exp_sel);
      chk($sformatf("v%0d setup paddr", i),   M_PADDR,   vecs[i].addr);
      chk($sformatf("v%0d setup pwrite", i),  M_PWRITE,  vecs[i].wr);
      chk($sformatf("v%0d setup pwdata", i),  M_PWDATA,  vecs[i].wdata);
      chk($sformatf("v%0d setup penable", i), M_PENABLE, 0);
      chk($sformatf("v%0d setup sready", i),  S_PREADY,  0);
      tick();
      e_prd = '0;
      e_prd[vecs[i].m*DW +: DW] = vecs[i].exp_rdata;
      e_rdy = '0;
      e_rdy[vecs[i].m] = 1'b1;
      chk($sformatf("v%0d access penable", i), M_PENABLE, 1);
      chk($sformatf("v%0d access psel", i),    M_PSELx,   vecs[i].exp_sel);
      chk($sformatf("v%0d access sready", i),  S_PREADY,  e_rdy);
      chk($sformatf("v%0d access sprdata", i), S_PRDATA,  e_prd);
      tick();
      chk($sformatf("v%0d idle penable", i), M_PENABLE, 0);
      chk($sformatf("v%0d idle psel", i),    M_PSELx,   0);
    end

    // Held request re-arbitrates every 3 cycles.
    set_master(2, 16'h0025, 1'b0, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("hold sready c%0d", k + 1), S_PREADY[2], exp_hold[k]);
      if (exp_hold[k] == 1) chk($sformatf("hold sprdata c%0d", k + 1), S_PRDATA[2*DW +: DW], 16'hBEEF);
    end
    S_PSELx = '0;
    tick();
    chk("hold idle psel", M_PSELx, 0);

    // Slave 1 stalls four ACCESS cycles, then completes combinationally.
    M_PREADY[1] = 1'b0;
    set_master(1, 16'h0010, 1'b0, 16'h0000);
    tick();
    S_PSELx = '0;
    for (int w = 0; w < 4; w++) begin
      tick();
      chk($sformatf("wait%0d penable", w), M_PENABLE, 1);
      chk($sformatf("wait%0d sready", w),  S_PREADY,  0);
      chk($sformatf("wait%0d psel", w),    M_PSELx,   4'b0010);
    end
    tick();
    M_PREADY[1] = 1'b1;
    #1;
    chk("wait done sready",  S_PREADY, 4'b0010);
    chk("wait done sprdata", S_PRDATA, 64'h0000_0000_2222_0000);
    tick();
    chk("wait idle penable", M_PENABLE, 0);

    // Asynchronous reset while stalled in ACCESS.
    M_PREADY[2] = 1'b0;
    set_master(2, 16'h0025, 1'b0, 16'h0000);
    tick();
    S_PSELx = '0;
    tick();
    chk("arst pre penable", M_PENABLE, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst psel",    M_PSELx, 0);
    chk("arst penable", M_PENABLE, 0);
    chk("arst paddr",   M_PADDR, 0);
    chk("arst sready",  S_PREADY, 0);
    tick();
    reset    = 1'b0;
    M_PREADY = 4'hF;

    // Contention among masters 0, 1, 3 after reset.
    set_master(0, 16'h0000, 1'b0, 16'h0000);
    set_master(1, 16'h0010, 1'b0, 16'h0000);
    set_master(3, 16'h0020, 1'b0, 16'h0000);
    pulses = '{0, 0, 0, 0};
    for (int c = 0; c < 40 && order.size() < 3; c++) begin
      tick();
      if (S_PREADY != 0) begin
        chk("cont onehot", $countones(S_PREADY), 1);
        for (int m = 0; m < MP; m++) begin
          if (S_PREADY[m]) begin
            order.push_back(m);
            pulses[m]++;
            S_PSELx[m] = 1'b0;
          end
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int m = 0; m < MP; m++) if (S_PREADY[m]) pulses[m]++;
    end
    chk("cont grants", order.size(), 3);
    for (int i = 0; i < order.size() && i < 3; i++)
      chk($sformatf("cont order%0d", i), order[i], exp_order[i]);
    chk("cont pulses m0", pulses[0], 1);
    chk("cont pulses m1", pulses[1], 1);
    chk("cont pulses m2", pulses[2], 0);
    chk("cont pulses m3", pulses[3], 1);

    // After master 3 last, master 0 wins the next round.
    set_master(1, 16'h0010, 1'b0, 16'h0000);
    set_master(0, 16'h0000, 1'b0, 16'h0000);
    tick();
    S_PSELx = '0;
    chk("round2 paddr", M_PADDR, 16'h0000);
    chk("round2 psel",  M_PSELx, 4'b0001);
    tick();
    chk("round2 sready", S_PREADY, 4'b0001);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_intercon_s.md
Name: apb_intercon_s

Overview:
- N-master to M-slave APB interconnect: arbitrates between core-side APB masters (S_* ports) and forwards one transaction at a time to a single shared slave bus (M_* ports).
- Slave select is decoded from address bits [ADDR_MSB:ADDR_LSB].
- Sits between the processor cores and the peripheral/shared-memory slaves of the cluster SoC.

Parameters:
- MASTER_PORTS, 4, number of master (core) ports.
- SLAVE_PORTS, 4, number of slave ports.
- BUS_WIDTH, 16, address width.
- DATA_WIDTH, 16, data width.
- ADDR_MSB, 7, MSB of the slave-index field in PADDR.
- ADDR_LSB, 4, LSB of the slave-index field in PADDR.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- S_PADDR  in  MASTER_PORTS*BUS_WIDTH  per-master address; slice i = [i*BUS_WIDTH +: BUS_WIDTH].
- S_PWRITE  in  MASTER_PORTS  per-master write flag.
- S_PSELx  in  MASTER_PORTS  per-master request/select.
- S_PENABLE  in  MASTER_PORTS  per-master enable; accepted but not required for a request.
- S_PWDATA  in  MASTER_PORTS*DATA_WIDTH  per-master write data.
- S_PRDATA  out  MASTER_PORTS*DATA_WIDTH  per-master read data.
- S_PREADY  out  MASTER_PORTS  per-master completion.
- M_PADDR  out  BUS_WIDTH  address to slaves.
- M_PWRITE  out  1  write flag to slaves.
- M_PSELx  out  SLAVE_PORTS  one-hot slave select.
- M_PENABLE  out  1  APB enable.
- M_PWDATA  out  DATA_WIDTH  write data to slaves.
- M_PRDATA  in  SLAVE_PORTS*DATA_WIDTH  per-slave read data.
- M_PREADY  in  SLAVE_PORTS  per-slave ready.

Behaviour:
- States: IDLE, SETUP, ACCESS.
- Reset (async): state=IDLE; latched grant=0; last_grant=MASTER_PORTS-1, so master 0 has first priority. All outputs are 0 during reset and in IDLE.
- IDLE:
  - If any S_PSELx bit is set, choose a grant by round-robin, searching upward (with wrap) from last_grant+1.
  - Register grant index, PADDR, PWRITE and PWDATA of the granted master; go to SETUP.
  - If no request, stay in IDLE.
- Slave index = latched PADDR[ADDR_MSB:ADDR_LSB].
  - If index < SLAVE_PORTS: valid. M_PSELx = one-hot(index).
  - Otherwise invalid: M_PSELx = 0.
- SETUP (1 cycle): drive M_PADDR, M_PWRITE, M_PWDATA from the latched values; M_PSELx as decoded; M_PENABLE=0. Go to ACCESS.
- ACCESS:
  - Same outputs as SETUP, with M_PENABLE=1.
  - Completion = M_PREADY[index], or 1 if the index is invalid.
  - On completion, in the same cycle (combinational): S_PREADY[grant]=1 and S_PRDATA[grant] = M_PRDATA[index] slice (0 if invalid or write). Then last_grant=grant and go to IDLE.
  - Without completion, wait in ACCESS; wait states are unbounded.
- S_PREADY/S_PRDATA for non-granted masters, and in all non-completing cycles, are 0.
- Latency: request present at edge k → SETUP in cycle k+1 → ACCESS in k+2. With zero-wait slave, S_PREADY is high during k+2. Minimum 3 cycles per transfer; transfers are back-to-back with one IDLE cycle between them.
- A master that holds S_PSELx after its S_PREADY is re-arbitrated as a new transfer. Round-robin prevents starvation.
- Master inputs are ignored after grant (latched values are used). A request dropped mid-transfer still completes on the slave side.
- Reset mid-transfer: immediate return to IDLE; all outputs go to 0.

Decomposition:
- Shared package: state encoding (IDLE/SETUP/ACCESS) and default width constants (16/16).
- One natural sub-module: apb_rr_arbiter (request vector + last_grant → grant index, valid), combinational.

Test Plan:
- Single read: reset 5 cycles; master 2 sets PADDR=0x0025, PSEL=PENABLE=1; slave 2 PREADY=1, PRDATA=0xBEEF.
  - → M_PSELx=4'b0100, M_PADDR=0x0025.
  - → M_PENABLE=0 then 1.
  - → S_PREADY[2]=1 with S_PRDATA[2 slice]=0xBEEF in the third cycle.
  - Held request repeats the transfer every 3 cycles.
- Write: master 0 writes 0x1234 to 0x0010 → M_PWRITE=1, M_PWDATA=0x1234, M_PSELx=4'b0010; S_PREADY[0] pulse.
- Contention: masters 0,1,3 request together → granted in order 0,1,3, each receiving exactly one S_PREADY pulse; next round starts at 0.
- Wait states: slave 1 holds PREADY=0 for 4 cycles → interconnect stays in ACCESS with M_PENABLE=1, S_PREADY=0; completes in the cycle PREADY rises.
- Invalid decode: PADDR=0x0050 (index 5) → M_PSELx=0, S_PREADY pulse with S_PRDATA=0 in ACCESS.
- Async reset asserted during ACCESS → all outputs 0 immediately; next request is granted starting from master 0.
